// File: rtl/minmax_pkg.sv
// Shared types for the streaming signed min/max tracker.
package minmax_pkg;
  localparam int WIDTH_C = 16;
  localparam int CNT_W_C = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Fields are sized for the widest count; narrower builds use the low bits.
  typedef struct packed {
    logic signed [WIDTH_C-1:0] max;
    logic signed [WIDTH_C-1:0] min;
    logic        [CNT_W_C-1:0] max_idx;
    logic        [CNT_W_C-1:0] min_idx;
    logic        [CNT_W_C-1:0] count;
  } result_t;
endpackage

// File: rtl/signed_comparator.sv
// Combinational two's-complement comparator: g = a > b, l = a < b.
module signed_comparator #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  output logic                g_o,
  output logic                l_o
);
  assign g_o = (a_i > b_i);
  assign l_o = (a_i < b_i);
endmodule

// File: rtl/minmax_tracker.sv
// Windowed signed min/max/index/count tracker over a valid/ready stream.
// Optional running sum output when MINMAX_TRACKER_SUM_EN is defined.
module minmax_tracker
  import minmax_pkg::*;
#(
  parameter int WIDTH = WIDTH_C,
  parameter int CNT_W = CNT_W_C
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_max,
  output logic signed [WIDTH-1:0] out_min,
  output logic        [CNT_W-1:0] out_max_idx,
  output logic        [CNT_W-1:0] out_min_idx,
`ifdef MINMAX_TRACKER_SUM_EN
  output logic signed [WIDTH+CNT_W-1:0] out_sum,
`endif
  output logic        [CNT_W-1:0] out_count
);
  localparam logic [CNT_W_C-1:0] SAT = CNT_W_C'((33'd1 << CNT_W) - 33'd1);

  state_t  state_q, state_d;
  result_t run_q, run_d, out_q;
  logic    in_fire, out_fire, cnt_sat, max_gt, min_lt;

  assign in_ready  = (state_q != HOLD) && !clear;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = (state_q == HOLD);
  assign out_fire  = out_valid && out_ready;
  assign cnt_sat   = (run_q.count == SAT);

  signed_comparator #(.W(WIDTH)) u_cmp_max (
    .a_i(in_data), .b_i(run_q.max), .g_o(max_gt), .l_o()
  );
  signed_comparator #(.W(WIDTH)) u_cmp_min (
    .a_i(in_data), .b_i(run_q.min), .g_o(), .l_o(min_lt)
  );

  // Strict compares keep the earlier index on ties; once saturated the count
  // stays put and doubles as the stamp for every later sample.
  always_comb begin
    run_d = run_q;
    if (state_q == IDLE) begin
      run_d.max     = in_data;
      run_d.min     = in_data;
      run_d.max_idx = '0;
      run_d.min_idx = '0;
      run_d.count   = CNT_W_C'(1);
    end else begin
      if (max_gt) begin
        run_d.max     = in_data;
        run_d.max_idx = run_q.count;
      end
      if (min_lt) begin
        run_d.min     = in_data;
        run_d.min_idx = run_q.count;
      end
      if (!cnt_sat) run_d.count = run_q.count + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear)                             state_d = IDLE;
    else if (in_fire)                      state_d = in_last ? HOLD : ACC;
    else if (state_q == HOLD && out_fire)  state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      run_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      if (in_fire)            run_q <= run_d;
      if (in_fire && in_last) out_q <= run_d;
    end
  end

  assign out_max     = out_q.max;
  assign out_min     = out_q.min;
  assign out_max_idx = out_q.max_idx[CNT_W-1:0];
  assign out_min_idx = out_q.min_idx[CNT_W-1:0];
  assign out_count   = out_q.count[CNT_W-1:0];

`ifdef MINMAX_TRACKER_SUM_EN
  logic signed [WIDTH+CNT_W-1:0] sum_q, sum_d, out_sum_q, smp_ext;

  assign smp_ext = {{CNT_W{in_data[WIDTH-1]}}, in_data};

  always_comb begin
    sum_d = sum_q;
    if (state_q == IDLE) sum_d = smp_ext;
    else if (!cnt_sat)   sum_d = sum_q + smp_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q     <= '0;
      out_sum_q <= '0;
    end else begin
      if (in_fire)            sum_q     <= sum_d;
      if (in_fire && in_last) out_sum_q <= sum_d;
    end
  end

  assign out_sum = out_sum_q;
`endif
endmodule

// File: tb/tb_minmax_tracker.sv
// Self-checking bench: directed table, corner sequences and random windows
// against a queue-based reference model; a 3-bit-count twin covers saturation.
module tb_minmax_tracker;
  localparam int NW    = 3;
  localparam int SAT_M = 65535;
  localparam int SAT_N = 7;

  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [15:0] in_data = '0;
  logic in_ready, out_valid, in_ready_n, out_valid_n;
  logic [15:0] out_max, out_min, out_max_idx, out_min_idx, out_count;
  logic [15:0] n_max, n_min;
  logic [NW-1:0] n_maxi, n_mini, n_cnt;
`ifdef MINMAX_TRACKER_SUM_EN
  logic [31:0] out_sum;
  logic [15+NW:0] n_sum;
`endif

  always #5 clk = ~clk;

  minmax_tracker dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_max(out_max),
    .out_min(out_min), .out_max_idx(out_max_idx), .out_min_idx(out_min_idx),
`ifdef MINMAX_TRACKER_SUM_EN
    .out_sum(out_sum),
`endif
    .out_count(out_count)
  );

  minmax_tracker #(.CNT_W(NW)) dut_n (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready_n), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_n), .out_ready(out_ready), .out_max(n_max),
    .out_min(n_min), .out_max_idx(n_maxi), .out_min_idx(n_mini),
`ifdef MINMAX_TRACKER_SUM_EN
    .out_sum(n_sum),
`endif
    .out_count(n_cnt)
  );

  typedef struct {
    longint mx, mn, mxi, mni, cnt, sum;
  } res_t;

  typedef struct {
    int          n;
    logic [15:0] s [8];
    res_t        e;
  } vec_t;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: first occurrence of each extreme, stamps capped at sat,
  // count capped at sat, sum over the first sat samples only.
  function automatic res_t model(input logic [15:0] q[$], input int sat);
    res_t r;
    longint v;
    r.mx = $signed(q[0]); r.mn = $signed(q[0]);
    r.mxi = 0; r.mni = 0; r.sum = 0;
    for (int k = 0; k < q.size(); k++) begin
      v = $signed(q[k]);
      if (v > r.mx) begin r.mx = v; r.mxi = k; end
      if (v < r.mn) begin r.mn = v; r.mni = k; end
      if (k < sat) r.sum += v;
    end
    if (r.mxi > sat) r.mxi = sat;
    if (r.mni > sat) r.mni = sat;
    r.cnt = (q.size() > sat) ? sat : q.size();
    return r;
  endfunction

  task automatic send(input logic [15:0] d, input logic last);
    int t = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    while (!in_ready && t < 50) begin tick(); t++; end
    if (!in_ready) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1");
    end
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_window(input logic [15:0] q[$], input int maxgap);
    for (int k = 0; k < q.size(); k++) begin
      if (maxgap > 0) repeat ($urandom_range(0, maxgap)) tick();
      send(q[k], k == q.size() - 1);
    end
  endtask

  task automatic check_main(input string tag, input res_t e);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_max"}, $signed(out_max), e.mx);
    chk({tag, "_min"}, $signed(out_min), e.mn);
    chk({tag, "_maxidx"}, out_max_idx, e.mxi);
    chk({tag, "_minidx"}, out_min_idx, e.mni);
    chk({tag, "_count"}, out_count, e.cnt);
`ifdef MINMAX_TRACKER_SUM_EN
    chk({tag, "_sum"}, $signed(out_sum), e.sum);
`endif
  endtask

  task automatic check_narrow(input string tag, input res_t e);
    chk({tag, "_n_valid"}, out_valid_n, 1);
    chk({tag, "_n_max"}, $signed(n_max), e.mx);
    chk({tag, "_n_min"}, $signed(n_min), e.mn);
    chk({tag, "_n_maxidx"}, n_maxi, e.mxi);
    chk({tag, "_n_minidx"}, n_mini, e.mni);
    chk({tag, "_n_count"}, n_cnt, e.cnt);
`ifdef MINMAX_TRACKER_SUM_EN
    chk({tag, "_n_sum"}, $signed(n_sum), e.sum);
`endif
  endtask

  // Backpressure for d cycles with a sample offered, then accept the result.
  task automatic drain(input string tag, input res_t e, input int d);
    for (int i = 0; i < d; i++) begin
      in_valid = 1'b1; in_last = 1'b1; in_data = 16'($urandom);
      out_ready = 1'b0;
      #1;
      chk({tag, "_bp_ready"}, in_ready, 0);
      tick();
      check_main({tag, "_bp"}, e);
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_post_valid"}, out_valid, 0);
    chk({tag, "_post_ready"}, in_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    logic [15:0] q[$];
    res_t e, en;

    tbl[0] = '{5, '{16'd5, -16'sd3, 16'd7, -16'sd3, 16'd2, 16'd0, 16'd0, 16'd0},
               '{7, -3, 2, 1, 5, 8}};
    tbl[1] = '{3, '{16'h7FFF, 16'h8000, 16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
               '{32767, -32768, 0, 1, 3, -2}};
    tbl[2] = '{3, '{16'd4, 16'd4, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
               '{4, 4, 0, 0, 3, 12}};
    tbl[3] = '{6, '{16'd3, 16'd2, 16'd1, 16'd0, -16'sd1, -16'sd2, 16'd0, 16'd0},
               '{3, -2, 0, 5, 6, 3}};
    tbl[4] = '{1, '{-16'sd100, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
               '{-100, -100, 0, 0, 1, -100}};
    tbl[5] = '{5, '{16'd1, 16'd9, 16'd9, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0},
               '{9, 0, 1, 4, 5, 20}};

    // Reset values
    tick(); tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_max", out_max, 0);
    chk("rst_count", out_count, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_minidx", out_min_idx, 0);

    // Directed table
    foreach (tbl[i]) begin
      q.delete();
      for (int k = 0; k < tbl[i].n; k++) q.push_back(tbl[i].s[k]);
      send_window(q, 0);
      check_main($sformatf("tbl%0d", i), tbl[i].e);
      check_narrow($sformatf("tbl%0d", i), model(q, SAT_N));
      drain($sformatf("tbl%0d", i), tbl[i].e, i % 3);
    end

    // Count saturation on the narrow twin
    q.delete();
    for (int k = 1; k <= 10; k++) q.push_back(16'(k));
    send_window(q, 0);
    check_main("sat", '{10, 1, 9, 0, 10, 55});
    check_narrow("sat", '{10, 1, 7, 0, 7, 28});
    drain("sat", '{10, 1, 9, 0, 10, 55}, 0);

    // Reset mid-window after 3 samples
    send(16'd50, 1'b0); send(-16'sd50, 1'b0); send(16'd60, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_max", out_max, 0);
    chk("mrst_min", out_min, 0);
    chk("mrst_maxidx", out_max_idx, 0);
    chk("mrst_count", out_count, 0);
    tick(); tick();
    rst_n = 1'b1;
    q = '{16'd9};
    send_window(q, 0);
    check_main("mrst9", '{9, 9, 0, 0, 1, 9});
    drain("mrst9", '{9, 9, 0, 0, 1, 9}, 0);

    // Long backpressure; next window must start at index 0
    q = '{16'd20, -16'sd20, 16'd30};
    send_window(q, 0);
    check_main("bp", '{30, -20, 2, 1, 3, 30});
    drain("bp", '{30, -20, 2, 1, 3, 30}, 10);
    q = '{-16'sd7, 16'd50};
    send_window(q, 0);
    check_main("bpnext", '{50, -7, 1, 0, 2, 43});
    drain("bpnext", '{50, -7, 1, 0, 2, 43}, 0);

    // Clear coincident with an offered sample after 2 samples
    send(16'd11, 1'b0); send(16'd12, 1'b0);
    in_valid = 1'b1; in_data = 16'd100; in_last = 1'b1; clear = 1'b1;
    #1;
    chk("clr_ready", in_ready, 0);
    tick();
    clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    chk("clr_valid0", out_valid, 0);
    tick();
    chk("clr_valid1", out_valid, 0);
    q = '{16'd4};
    send_window(q, 0);
    check_main("clr4", '{4, 4, 0, 0, 1, 4});

    // Clear while holding a result
    clear = 1'b1;
    tick();
    chk("hclr_valid", out_valid, 0);
    chk("hclr_ready_clr", in_ready, 0);
    chk("hclr_keep_max", $signed(out_max), 4);
    clear = 1'b0;
    #1;
    chk("hclr_ready", in_ready, 1);

    // Random windows with gaps and backpressure
    for (int w = 0; w < 30; w++) begin
      int len;
      len = $urandom_range(1, 12);
      q.delete();
      for (int k = 0; k < len; k++) begin
        case ($urandom_range(0, 3))
          0: case ($urandom_range(0, 3))
               0: q.push_back(16'h7FFF);
               1: q.push_back(16'h8000);
               2: q.push_back(16'h0000);
               default: q.push_back(16'hFFFF);
             endcase
          1: q.push_back(16'($urandom_range(0, 4)));
          default: q.push_back(16'($urandom));
        endcase
      end
      e  = model(q, SAT_M);
      en = model(q, SAT_N);
      send_window(q, 2);
      check_main($sformatf("rnd%0d", w), e);
      check_narrow($sformatf("rnd%0d", w), en);
      drain($sformatf("rnd%0d", w), e, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
